// File: rtl/fv_stream_receiver.sv
// Edge-PE receiver for the FV stream: filters beats by PE tag, assembles one
// framed packet into a line buffer and holds it until the datapath consumes it.
module fv_stream_receiver #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 2,
    parameter int MAX_LINES = 8,
    parameter int IDX_W     = $clog2(MAX_LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  my_tag,
    input  logic              in_valid,
    input  logic              in_sos,
    input  logic              in_eos,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              fv_ready,
    output logic [IDX_W:0]    fv_lines,
    input  logic              consume,
    output logic              busy,
    output logic              err_framing,
    output logic              err_overflow,
    output logic              err_drop,
    input  logic              err_clr,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_LINES);
    localparam logic [IDX_W:0] ONE     = (IDX_W + 1)'(1);

    logic [DATA_W-1:0] line_mem [MAX_LINES];

    logic [1:0]       state;
    logic [1:0]       nxt_state;
    logic [IDX_W:0]   wr_cnt;
    logic [IDX_W:0]   nxt_cnt;
    logic [IDX_W:0]   nxt_lines;
    logic             match;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic             set_framing;
    logic             set_overflow;
    logic             set_drop;

    assign match     = in_valid && (in_tag == my_tag);
    assign fv_ready  = (state == READY);
    assign busy      = (state == RECV);
    assign fsm_state = state;

    always_comb begin
        nxt_state    = state;
        nxt_cnt      = wr_cnt;
        nxt_lines    = fv_lines;
        we           = 1'b0;
        waddr        = '0;
        set_framing  = 1'b0;
        set_overflow = 1'b0;
        set_drop     = 1'b0;
        case (state)
            IDLE: begin
                if (match && in_sos) begin
                    we      = 1'b1;
                    nxt_cnt = ONE;
                    if (in_eos) begin
                        nxt_state = READY;
                        nxt_lines = ONE;
                    end else begin
                        nxt_state = RECV;
                    end
                end else if (match) begin
                    set_framing = 1'b1;
                end
            end
            RECV: begin
                if (match && in_sos) begin
                    // A fresh sos mid-packet restarts reception at line 0.
                    set_framing = 1'b1;
                    we          = 1'b1;
                    nxt_cnt     = ONE;
                    if (in_eos) begin
                        nxt_state = READY;
                        nxt_lines = ONE;
                    end
                end else if (match) begin
                    if (wr_cnt < MAX_CNT) begin
                        we      = 1'b1;
                        waddr   = wr_cnt[IDX_W-1:0];
                        nxt_cnt = wr_cnt + ONE;
                    end else begin
                        set_overflow = 1'b1;
                    end
                    if (in_eos) begin
                        nxt_state = READY;
                        nxt_lines = nxt_cnt;
                    end
                end
            end
            READY: begin
                if (consume && match && in_sos) begin
                    we      = 1'b1;
                    nxt_cnt = ONE;
                    if (in_eos) begin
                        nxt_state = READY;
                        nxt_lines = ONE;
                    end else begin
                        nxt_state = RECV;
                        nxt_lines = '0;
                    end
                end else begin
                    if (match) begin
                        set_drop = 1'b1;
                    end
                    if (consume) begin
                        nxt_state = IDLE;
                        nxt_lines = '0;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
                nxt_lines = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            line_mem[waddr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            fv_lines     <= '0;
            rd_data      <= '0;
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            state    <= nxt_state;
            wr_cnt   <= nxt_cnt;
            fv_lines <= nxt_lines;
            rd_data  <= (fv_ready && ({1'b0, rd_addr} < fv_lines)) ? line_mem[rd_addr] : '0;
            // A new error event in the same cycle as err_clr keeps the flag set.
            err_framing  <= set_framing  | (err_framing  & ~err_clr);
            err_overflow <= set_overflow | (err_overflow & ~err_clr);
            err_drop     <= set_drop     | (err_drop     & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fv_stream_receiver.sv
// Self-checking bench for fv_stream_receiver: scenario tasks with inline checks
// plus a read-port scoreboard fed by an expected-data queue.
module tb_fv_stream_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  my_tag;
    logic        in_valid;
    logic        in_sos;
    logic        in_eos;
    logic [1:0]  in_tag;
    logic [15:0] in_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        fv_ready;
    logic [3:0]  fv_lines;
    logic        consume;
    logic        busy;
    logic        err_framing;
    logic        err_overflow;
    logic        err_drop;
    logic        err_clr;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic        rd_chk   = 1'b0;
    logic        rd_chk_d = 1'b0;

    fv_stream_receiver dut (
        .clk(clk), .reset(reset), .my_tag(my_tag),
        .in_valid(in_valid), .in_sos(in_sos), .in_eos(in_eos),
        .in_tag(in_tag), .in_data(in_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .fv_ready(fv_ready), .fv_lines(fv_lines), .consume(consume),
        .busy(busy), .err_framing(err_framing), .err_overflow(err_overflow),
        .err_drop(err_drop), .err_clr(err_clr), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Read scoreboard: a read issued before an edge is compared after that edge.
    always @(posedge clk) rd_chk_d <= rd_chk;
    always @(negedge clk) begin
        if (rd_chk_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_underflow got=%h with no expected entry", rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=%h", rd_data, e);
                end
            end
        end
    end

    task automatic clear_inputs();
        in_valid = 0; in_sos = 0; in_eos = 0; in_tag = 0; in_data = 0;
        consume = 0; err_clr = 0;
    endtask

    task automatic step(input logic v, input logic s, input logic e, input logic [1:0] tag,
                        input logic [15:0] d, input logic cons, input logic clr);
        @(negedge clk);
        in_valid = v; in_sos = s; in_eos = e; in_tag = tag; in_data = d;
        consume = cons; err_clr = clr;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic issue_read(input logic [2:0] addr, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = addr;
        rd_chk  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (fv_ready !== 1'b0) begin failures++; $display("FAIL reset_fv_ready got=%b exp=0", fv_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fv_lines !== 4'd0) begin failures++; $display("FAIL reset_fv_lines got=%0d exp=0", fv_lines); end
        checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({err_framing, err_overflow, err_drop} !== 3'b000) begin failures++; $display("FAIL reset_errs got=%b exp=000", {err_framing, err_overflow, err_drop}); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_single();
        step(1, 1, 1, 2'd1, 16'h1234, 0, 0);
        checks++; if (fv_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", fv_ready); end
        checks++; if (fv_lines !== 4'd1) begin failures++; $display("FAIL single_lines got=%0d exp=1", fv_lines); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
        issue_read(3'd0, 16'h1234);
        issue_read(3'd1, 16'h0000);
        step(0, 0, 0, 2'd0, 16'h0, 1, 0);
        checks++; if (fv_ready !== 1'b0 || fv_lines !== 4'd0) begin failures++; $display("FAIL single_consume got=%b/%0d exp=0/0", fv_ready, fv_lines); end
        issue_read(3'd0, 16'h0000);
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 4; i++) begin
            step(1, i == 0, i == 3, 2'd1, 16'hA0 + 16'(i), 0, 0);
            if (i < 3) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ilv_busy beat=%0d got=%b exp=1", i, busy); end
                step(1, 1'(i == 1), 1'(i == 2), 2'd2, 16'(16'hF0 + $urandom_range(0, 15)), 0, 0);
            end
        end
        checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'd4) begin failures++; $display("FAIL ilv_lines got=%b/%0d exp=1/4", fv_ready, fv_lines); end
        checks++; if ({err_framing, err_overflow, err_drop} !== 3'b000) begin failures++; $display("FAIL ilv_errs got=%b exp=000", {err_framing, err_overflow, err_drop}); end
        for (int i = 0; i < 5; i++) issue_read(3'(i), (i < 4) ? 16'hA0 + 16'(i) : 16'h0);
        step(0, 0, 0, 2'd0, 16'h0, 1, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            step(1, i == 0, i == 9, 2'd1, 16'hB0 + 16'(i), 0, 0);
            if (i == 7) begin
                checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", err_overflow); end
            end
        end
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
        checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'd8) begin failures++; $display("FAIL ovf_lines got=%b/%0d exp=1/8", fv_ready, fv_lines); end
        for (int i = 0; i < 8; i++) issue_read(3'(i), 16'hB0 + 16'(i));
        step(0, 0, 0, 2'd0, 16'h0, 1, 1);
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", err_overflow); end
    endtask

    task automatic test_framing();
        step(1, 0, 0, 2'd1, 16'h0077, 0, 0);
        checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL frm_idle_flag got=%b exp=1", err_framing); end
        checks++; if (fsm_state !== 2'd0 || busy !== 1'b0 || fv_ready !== 1'b0) begin failures++; $display("FAIL frm_idle_state got=%0d exp=0", fsm_state); end
        step(1, 1, 0, 2'd1, 16'h0011, 0, 0);
        step(1, 1, 0, 2'd1, 16'h0022, 0, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frm_restart_busy got=%b exp=1", busy); end
        step(1, 0, 1, 2'd1, 16'h0033, 0, 0);
        checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'd2) begin failures++; $display("FAIL frm_lines got=%b/%0d exp=1/2", fv_ready, fv_lines); end
        issue_read(3'd0, 16'h0022);
        issue_read(3'd1, 16'h0033);
        step(0, 0, 0, 2'd0, 16'h0, 0, 1);
        checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL frm_clr got=%b exp=0", err_framing); end
        // Error event and clear in the same cycle: the set must win.
        step(0, 0, 0, 2'd0, 16'h0, 1, 0);
        step(1, 0, 0, 2'd1, 16'h0099, 0, 1);
        checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL frm_set_wins got=%b exp=1", err_framing); end
        step(0, 0, 0, 2'd0, 16'h0, 0, 1);
    endtask

    task automatic test_held();
        step(1, 1, 0, 2'd1, 16'h00C0, 0, 0);
        step(1, 0, 1, 2'd1, 16'h00C1, 0, 0);
        step(1, 1, 0, 2'd1, 16'h00D0, 0, 0);
        checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL held_drop got=%b exp=1", err_drop); end
        step(1, 0, 1, 2'd1, 16'h00D1, 0, 0);
        checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'd2) begin failures++; $display("FAIL held_frozen got=%b/%0d exp=1/2", fv_ready, fv_lines); end
        issue_read(3'd0, 16'h00C0);
        issue_read(3'd1, 16'h00C1);
        step(0, 0, 0, 2'd0, 16'h0, 0, 1);
        step(1, 1, 1, 2'd1, 16'h0055, 1, 0);
        checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'd1) begin failures++; $display("FAIL held_swap got=%b/%0d exp=1/1", fv_ready, fv_lines); end
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL held_no_drop got=%b exp=0", err_drop); end
        issue_read(3'd0, 16'h0055);
        issue_read(3'd1, 16'h0000);
        step(0, 0, 0, 2'd0, 16'h0, 1, 0);
    endtask

    task automatic test_mid_reset();
        step(1, 1, 0, 2'd1, 16'h00E0, 0, 0);
        step(1, 0, 0, 2'd1, 16'h00E1, 0, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mrst_busy got=%b exp=1", busy); end
        pulse_reset();
        checks++; if ({fv_ready, busy, fv_lines, rd_data, err_framing, err_overflow, err_drop} !== '0) begin failures++; $display("FAIL mrst_outputs got=%b/%b/%0d/%h exp=0", fv_ready, busy, fv_lines, rd_data); end
        step(1, 0, 0, 2'd1, 16'h00E2, 0, 0);
        step(1, 0, 1, 2'd1, 16'h00E3, 0, 0);
        checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL mrst_framing got=%b exp=1", err_framing); end
        checks++; if (fv_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mrst_no_ready got=%b/%b exp=0/0", fv_ready, busy); end
        step(0, 0, 0, 2'd0, 16'h0, 0, 1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            int n;
            logic [15:0] d [8];
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                d[i] = 16'($urandom_range(0, 16'hFFFF));
                step(1, i == 0, i == n - 1, 2'd1, d[i], 0, 0);
                if ($urandom_range(0, 1) == 1) step(1, 0, 0, 2'($urandom_range(2, 3)), 16'hDEAD, 0, 0);
            end
            checks++; if (fv_ready !== 1'b1 || fv_lines !== 4'(n)) begin failures++; $display("FAIL rnd_lines pkt=%0d got=%b/%0d exp=1/%0d", p, fv_ready, fv_lines, n); end
            for (int i = 0; i < 8; i++) issue_read(3'(i), (i < n) ? d[i] : 16'h0);
            step(0, 0, 0, 2'd0, 16'h0, 1, 0);
        end
        checks++; if ({err_framing, err_overflow, err_drop} !== 3'b000) begin failures++; $display("FAIL rnd_errs got=%b exp=000", {err_framing, err_overflow, err_drop}); end
    endtask

    initial begin
        clear_inputs();
        my_tag  = 2'd1;
        rd_addr = 3'd0;
        reset   = 1'b0;
        test_reset();
        test_single();
        test_interleave();
        test_overflow();
        test_framing();
        test_held();
        test_mid_reset();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rd_queue_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
